sdram_arbiter: RTL and testbench

- Shares the single SDRAMBus request port (sdram_addr/read/write/writedata/readdata/finished) among the five AcappellaCore requesters: 0 = load, 1 = mix, 2 = pitch, 3 = record, 4 = play.
- Replaces the current OR-ing of addresses and hard-wiring of read/write.
- Grants exactly one requester per SDRAM transaction. Real-time ports (record, play) take priority; round-robin fairness applies within each class.

---
 rtl/sdram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - five-way SDRAMBus arbiter, real-time class first, round-robin per class
module sdram_arbiter #(
    parameter int             N       = 5,
    parameter int             AW      = 23,
    parameter int             DW      = 32,
    parameter logic [N-1:0]   HI_MASK = 5'b11000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      req_read,
    input  logic [N-1:0]      req_write,
    input  logic [N*AW-1:0]   req_addr,
    input  logic [N*DW-1:0]   req_writedata,
    output logic [DW-1:0]     req_readdata,
    output logic [N-1:0]      req_finished,
    output logic [AW-1:0]     sdram_addr,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [DW-1:0]     sdram_writedata,
    input  logic [DW-1:0]     sdram_readdata,
    input  logic              sdram_finished,
    output logic [N-1:0]      grant,
    output logic              protocol_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   hi_ptr_q, hi_ptr_d;
    logic [PW-1:0]   lo_ptr_q, lo_ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [N-1:0]    fin_q, fin_d;
    logic            err_q, err_d;
    // Set when a reset cut an SDRAMBus transaction short; swallows its late finish.
    logic            abandon_q, abandon_d;

    logic [N-1:0]    pending, hi_pend, lo_pend, cand;
    logic            use_hi;
    logic [PW-1:0]   start_ptr, g_idx, next_ptr, rr_idx;
    logic [PW:0]     rr_sum;
    logic            g_found;

    // Pick the winner: high class if any of it is pending, round-robin from that class's pointer.
    always_comb begin
        pending   = req_read | req_write;
        hi_pend   = pending & HI_MASK;
        lo_pend   = pending & ~HI_MASK;
        use_hi    = |hi_pend;
        cand      = use_hi ? hi_pend : lo_pend;
        start_ptr = use_hi ? hi_ptr_q : lo_ptr_q;
        g_idx     = '0;
        g_found   = 1'b0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < N; k++) begin
            rr_sum = {1'b0, start_ptr} + (PW+1)'(k);
            rr_idx = (rr_sum >= (PW+1)'(N)) ? PW'(rr_sum - (PW+1)'(N)) : PW'(rr_sum);
            if (!g_found && cand[rr_idx]) begin
                g_found = 1'b1;
                g_idx   = rr_idx;
            end
        end
        next_ptr = (g_idx == PW'(N - 1)) ? '0 : g_idx + 1'b1;
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/RELEASE sequence.
    always_comb begin
        state_d   = state_q;
        hi_ptr_d  = hi_ptr_q;
        lo_ptr_d  = lo_ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
        fin_d     = fin_q;
        err_d     = err_q;
        abandon_d = abandon_q;
        unique case (state_q)
            IDLE: begin
                if (sdram_finished) begin
                    if (abandon_q) abandon_d = 1'b0;
                    else           err_d     = 1'b1;
                end
                if (g_found) begin
                    state_d        = ISSUE;
                    abandon_d      = 1'b0;
                    grant_d        = '0;
                    grant_d[g_idx] = 1'b1;
                    addr_d         = req_addr[g_idx*AW +: AW];
                    wdata_d        = req_writedata[g_idx*DW +: DW];
                    wr_d           = req_write[g_idx];
                    rd_d           = req_read[g_idx] & ~req_write[g_idx];
                    if (req_read[g_idx] & req_write[g_idx]) err_d = 1'b1;
                    if (use_hi) hi_ptr_d = next_ptr;
                    else        lo_ptr_d = next_ptr;
                end
            end
            ISSUE: begin
                if (sdram_finished) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = sdram_readdata;
                    fin_d   = grant_q;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (sdram_finished) err_d = 1'b1;
                fin_d   = '0;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; a reset mid-transaction remembers that a finish may still arrive.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            hi_ptr_q  <= '0;
            lo_ptr_q  <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            fin_q     <= '0;
            err_q     <= 1'b0;
            abandon_q <= abandon_q | (state_q == ISSUE);
        end else begin
            state_q   <= state_d;
            hi_ptr_q  <= hi_ptr_d;
            lo_ptr_q  <= lo_ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rdata_q   <= rdata_d;
            fin_q     <= fin_d;
            err_q     <= err_d;
            abandon_q <= abandon_d;
        end
    end

    assign grant           = grant_q;
    assign sdram_addr      = addr_q;
    assign sdram_writedata = wdata_q;
    assign sdram_read      = rd_q;
    assign sdram_write     = wr_q;
    assign req_readdata    = rdata_q;
    assign req_finished    = fin_q;
    assign protocol_err    = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

    localparam int N  = 5;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam logic [4:0] HI = 5'b11000;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic [N-1:0]      req_read = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_writedata;
    logic [DW-1:0]     req_readdata;
    logic [N-1:0]      req_finished;
    logic [AW-1:0]     sdram_addr;
    logic              sdram_read;
    logic              sdram_write;
    logic [DW-1:0]     sdram_writedata;
    logic [DW-1:0]     sdram_readdata = '0;
    logic              sdram_finished = 1'b0;
    logic [N-1:0]      grant;
    logic              protocol_err;

    logic [AW-1:0]     a_addr [N];
    logic [DW-1:0]     a_wd   [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_addr[gi*AW +: AW]      = a_addr[gi];
        assign req_writedata[gi*DW +: DW] = a_wd[gi];
    end

    sdram_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_writedata(req_writedata),
        .req_readdata(req_readdata), .req_finished(req_finished),
        .sdram_addr(sdram_addr), .sdram_read(sdram_read), .sdram_write(sdram_write),
        .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
        .sdram_finished(sdram_finished), .grant(grant), .protocol_err(protocol_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err    = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: which requester owns the bus, and in which phase.
    int           m_ph = 0;   // 0 waiting for requests, 1 bus busy, 2 handing back
    int           m_hp = 0;
    int           m_lp = 0;
    bit           m_ab = 0;
    logic [4:0]   e_grant = '0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0;
    logic         e_rd = 0, e_wr = 0, e_err = 0;
    logic [DW-1:0] e_rdata = '0;
    logic [4:0]   e_fin = '0;

    function automatic int pick(input logic [4:0] pend, input int ptr);
        for (int k = 0; k < N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        logic [4:0] pend;
        int g;
        if (!i_rst) begin
            if (m_ph == 1) m_ab = 1;
            m_ph = 0; m_hp = 0; m_lp = 0;
            e_grant = '0; e_addr = '0; e_wd = '0; e_rd = 0; e_wr = 0;
            e_err = 0; e_rdata = '0; e_fin = '0;
            return;
        end
        case (m_ph)
            0: begin
                if (sdram_finished) begin
                    if (m_ab) m_ab = 0;
                    else      e_err = 1;
                end
                pend = req_read | req_write;
                g = -1;
                if ((pend & HI) != 0) begin
                    g = pick(pend & HI, m_hp);
                    m_hp = (g + 1) % N;
                end else if (pend != 0) begin
                    g = pick(pend & ~HI, m_lp);
                    m_lp = (g + 1) % N;
                end
                if (g >= 0) begin
                    m_ph = 1; m_ab = 0;
                    e_grant = 5'(1 << g);
                    e_addr = a_addr[g];
                    e_wd = a_wd[g];
                    e_wr = req_write[g];
                    e_rd = req_read[g] && !req_write[g];
                    if (req_read[g] && req_write[g]) e_err = 1;
                end
            end
            1: if (sdram_finished) begin
                e_rd = 0; e_wr = 0; e_rdata = sdram_readdata; e_fin = e_grant; m_ph = 2;
            end
            default: begin
                if (sdram_finished) e_err = 1;
                e_fin = '0; e_grant = '0; m_ph = 0;
            end
        endcase
    endtask

    // Compare every registered output against the model once per cycle.
    always @(negedge i_clk) begin
        if (check_en) begin
            chk("grant", grant, e_grant);
            chk("sdram_read", sdram_read, e_rd);
            chk("sdram_write", sdram_write, e_wr);
            chk("sdram_addr", sdram_addr, e_addr);
            chk("sdram_writedata", sdram_writedata, e_wd);
            chk("req_readdata", req_readdata, e_rdata);
            chk("req_finished", req_finished, e_fin);
            chk("protocol_err", protocol_err, e_err);
        end
    end

    // SDRAMBus emulation and requester behaviour
    bit          auto_resp = 1;
    int          lat = 4;
    int          lat_cnt = 0;
    logic [DW-1:0] rd_val = '0;
    bit          force_fin = 0;
    logic [4:0]  drop_mask = '1;
    logic [4:0]  last_grant = '0;
    int          glog[$];
    logic [DW-1:0] wlog[$];
    int          fin_seen = 0;

    task automatic cyc();
        sdram_finished = force_fin;
        force_fin = 0;
        if (auto_resp && (sdram_read || sdram_write)) begin
            if (lat_cnt == lat - 1) begin
                sdram_finished = 1'b1;
                sdram_readdata = rd_val;
                lat_cnt = 0;
            end else lat_cnt++;
        end else lat_cnt = 0;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        for (int i = 0; i < N; i++)
            if (req_finished[i] && drop_mask[i]) begin
                req_read[i] = 1'b0;
                req_write[i] = 1'b0;
            end
        if (req_finished != 0) fin_seen++;
        if (grant != 0 && grant != last_grant) begin
            for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
            wlog.push_back(sdram_writedata);
        end
        last_grant = grant;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (((req_read | req_write) != 0 || grant != 0) && c < bound) begin
            cyc();
            c++;
        end
        chk("wait_idle_bound", (c < bound), 1);
    endtask

    task automatic wait_glog(input int n, input int bound);
        int c = 0;
        while (glog.size() < n && c < bound) begin
            cyc();
            c++;
        end
        chk("wait_grant_bound", (c < bound), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd, nfin, fin_at, gz;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = AW'(32'h1000 * (i + 1));
            a_wd[i]   = 32'hA000_0000 + 32'(i);
        end
        // Reset
        i_rst = 1'b0;
        cyc();
        check_en = 1'b1;
        cyc();
        i_rst = 1'b1;
        chk("rst_grant", grant, 5'b00000);
        chk("rst_err", protocol_err, 0);
        chk("rst_rd", sdram_read, 0);
        cyc();

        // 1: play read, 4-cycle SDRAM latency
        lat = 4; rd_val = 32'hDEADBEEF; drop_mask = '1;
        a_addr[4] = 23'h000100;
        req_read[4] = 1'b1;
        cyc();
        chk("t1_read_next_cycle", sdram_read, 1);
        chk("t1_addr", sdram_addr, 23'h000100);
        chk("t1_grant", grant, 5'b10000);
        nrd = 1; nfin = 0; fin_at = -1; gz = -1;
        for (int c = 0; c < 7; c++) begin
            cyc();
            nrd += int'(sdram_read);
            if (req_finished == 5'b10000) begin
                nfin++;
                fin_at = c;
                chk("t1_rdata", req_readdata, 32'hDEADBEEF);
            end
            if (grant == 0 && gz < 0) gz = c;
        end
        chk("t1_read_cycles", nrd, 4);
        chk("t1_fin_pulses", nfin, 1);
        chk("t1_fin_at", fin_at, 3);
        chk("t1_grant_zero_at", gz, 4);

        // 2: record + play held, load waiting
        lat = 2; glog.delete(); wlog.delete();
        drop_mask = 5'b00001;
        req_write[3] = 1'b1; req_read[4] = 1'b1; req_read[0] = 1'b1;
        wait_glog(4, 80);
        req_write[3] = 1'b0;
        drop_mask = 5'b10001;
        wait_idle(80);
        chk("t2_n", glog.size(), 5);
        if (glog.size() == 5) begin
            chk("t2_g0", glog[0], 3);
            chk("t2_g1", glog[1], 4);
            chk("t2_g2", glog[2], 3);
            chk("t2_g3", glog[3], 4);
            chk("t2_g4", glog[4], 0);
        end

        // 3: mix and pitch writing continuously
        glog.delete(); wlog.delete();
        a_wd[1] = 32'h1111_0001; a_wd[2] = 32'h2222_0002;
        drop_mask = 5'b00000;
        req_write[1] = 1'b1; req_write[2] = 1'b1;
        wait_glog(4, 80);
        drop_mask = 5'b00110;
        wait_idle(80);
        if (glog.size() >= 4) begin
            chk("t3_g0", glog[0], 1);
            chk("t3_g1", glog[1], 2);
            chk("t3_g2", glog[2], 1);
            chk("t3_g3", glog[3], 2);
            chk("t3_w0", wlog[0], 32'h1111_0001);
            chk("t3_w1", wlog[1], 32'h2222_0002);
            chk("t3_w3", wlog[3], 32'h2222_0002);
        end else chk("t3_n", glog.size(), 4);

        // 4: read and write together
        drop_mask = '1;
        chk("t4_err_before", protocol_err, 0);
        a_addr[2] = 23'h0002AA; a_wd[2] = 32'hCAFE_F00D;
        req_read[2] = 1'b1; req_write[2] = 1'b1;
        cyc();
        chk("t4_write", sdram_write, 1);
        chk("t4_read", sdram_read, 0);
        chk("t4_wdata", sdram_writedata, 32'hCAFE_F00D);
        chk("t4_err", protocol_err, 1);
        wait_idle(40);
        chk("t4_err_sticky", protocol_err, 1);

        // 5: reset during ISSUE, late finish, then all pending
        auto_resp = 0;
        req_read[1] = 1'b1;
        cyc(); cyc(); cyc();
        chk("t5_in_issue", sdram_read, 1);
        chk("t5_grant", grant, 5'b00010);
        fin_seen = 0;
        i_rst = 1'b0; req_read = '0;
        cyc(); cyc();
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_rd", sdram_read, 0);
        chk("t5_rst_addr", sdram_addr, 0);
        chk("t5_rst_err", protocol_err, 0);
        i_rst = 1'b1; auto_resp = 1;
        force_fin = 1;
        cyc();
        cyc();
        chk("t5_late_fin_err", protocol_err, 0);
        chk("t5_no_fin", fin_seen, 0);
        glog.delete();
        req_read = 5'b11111;
        cyc();
        chk("t5_first_grant", grant, 5'b01000);
        wait_idle(100);
        chk("t5_n", glog.size(), 5);
        if (glog.size() == 5) begin
            chk("t5_g1", glog[1], 4);
            chk("t5_g2", glog[2], 0);
            chk("t5_g3", glog[3], 1);
            chk("t5_g4", glog[4], 2);
        end

        // 6: spurious finish while idle
        fin_seen = 0;
        force_fin = 1;
        cyc();
        cyc();
        chk("t6_err", protocol_err, 1);
        chk("t6_no_fin", fin_seen, 0);
        chk("t6_grant", grant, 0);
        a_addr[0] = 23'h7FFFFF;
        req_read[0] = 1'b1;
        cyc();
        chk("t6_read_after", sdram_read, 1);
        chk("t6_addr_max", sdram_addr, 23'h7FFFFF);
        chk("t6_grant_after", grant, 5'b00001);
        wait_idle(40);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
